// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, rounding-mode encodings, result classes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_pkg;

    // Bit positions inside the 4-bit {NV, OF, UF, NX} flag vector.
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // rnd_mode encodings.
    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    // Result class decided in S1, already resolved by priority.
    typedef enum logic [2:0] {
        CLS_FIN  = 3'd0,
        CLS_ZERO = 3'd1,
        CLS_INF  = 3'd2,
        CLS_NAN  = 3'd3,
        CLS_OVF  = 3'd4
    } fp_cls_e;

    // Canonical quiet NaN right-aligned in a wide word: sign 0, exponent all
    // ones, fraction MSB set. Callers slice off the low 1+exp_w+man_w bits.
    function automatic logic [127:0] canonical_nan(input int exp_w, input int man_w);
        logic [127:0] one;
        one = 128'd1;
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_denorm_shifter.sv
// Right-aligns {hidden, fraction, g, r, s} for a tiny result, folding shifted-out bits into sticky.
// Latency: combinational.
// Backpressure: none (pure datapath).
//   din   : {1'b1, man, grs}, MAN_W+4 bits
//   shamt : right shift amount, caller saturates it at MAN_W+3
//   dout  : {frac, g, r, s} after the shift, MAN_W+3 bits
module fpu_denorm_shifter #(
    parameter int MAN_W = 23,
    localparam int W    = MAN_W + 4,
    localparam int SH_W = $clog2(MAN_W + 4)
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] shamt,
    output logic [W-2:0]    dout
);

    logic [W-1:0] lost_mask;
    logic         sticky;

    assign lost_mask = ~({W{1'b1}} << shamt);
    assign sticky    = |(din & lost_mask);

    // The hidden-bit slot is dropped: callers always shift by at least one,
    // so that slot is empty after the shift.
    assign dout = (W-1)'(din >> shamt) | (W-1)'(sticky);

endmodule

// File: rtl/fpu_result_pack.sv
// Rounds and packs a normalized FPU result into IEEE format with per-beat and sticky flags.
// Latency: 2 cycles (S1 classify/denormalize, S2 round/pack), one beat per cycle.
// Backpressure: valid/ready; each stage loads when empty or draining, output held while stalled.
//   in_*        : beat (sign, signed biased exp, fraction, grs, classification, rnd_mode)
//   out_*       : packed {sign, exp, frac} result and {NV, OF, UF, NX} flags
//   flag_clr    : clears status_flags, which accumulates flags of accepted output beats
module fpu_result_pack
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W+1:0]   in_exp,
    input  logic [MAN_W-1:0]   in_man,
    input  logic [2:0]         in_grs,
    input  logic               in_invalid,
    input  logic               in_inf,
    input  logic               in_zero,
    input  logic               rnd_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [3:0]         out_flags,
    input  logic               flag_clr,
    output logic [3:0]         status_flags
);

    localparam int SH_W    = $clog2(MAN_W + 4);
    localparam int MAX_EXP = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAXF = EXP_W'(MAX_EXP - 1);
    localparam logic [127:0] NAN_WIDE = canonical_nan(EXP_W, MAN_W);
    localparam logic [EXP_W+MAN_W:0] NAN_BITS = NAN_WIDE[EXP_W+MAN_W:0];

    // ---------------- S1: classify and denormalize ----------------
    logic signed [EXP_W+1:0] exp_s;
    logic                    tiny_d;
    fp_cls_e                 cls_d;
    logic [SH_W-1:0]         sh_amt;
    logic [MAN_W+2:0]        den_out;
    logic [EXP_W-1:0]        exp_d;
    logic [MAN_W-1:0]        frac_d;
    logic [2:0]              grs_d;
    int                      sh_full;

    assign exp_s  = $signed(in_exp);
    assign tiny_d = (exp_s <= 0);

    always_comb begin
        sh_full = 1 - int'(exp_s);
        sh_amt  = '0;
        if (tiny_d) begin
            sh_amt = (sh_full > MAN_W + 3) ? SH_W'(MAN_W + 3) : SH_W'(sh_full);
        end
    end

    fpu_denorm_shifter #(.MAN_W(MAN_W)) u_shift (
        .din   ({1'b1, in_man, in_grs}),
        .shamt (sh_amt),
        .dout  (den_out)
    );

    always_comb begin
        cls_d  = CLS_FIN;
        exp_d  = in_exp[EXP_W-1:0];
        frac_d = in_man;
        grs_d  = in_grs;
        if (in_invalid)                    cls_d = CLS_NAN;
        else if (in_inf)                   cls_d = CLS_INF;
        else if (in_zero)                  cls_d = CLS_ZERO;
        else if (int'(exp_s) >= MAX_EXP)   cls_d = CLS_OVF;
        if (tiny_d) begin
            exp_d  = '0;
            frac_d = den_out[MAN_W+2:3];
            grs_d  = den_out[2:0];
        end
    end

    logic             s1_valid;
    logic             s1_sign;
    fp_cls_e          s1_cls;
    logic             s1_tiny;
    logic             s1_rnd;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_frac;
    logic [2:0]       s1_grs;
    logic             s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_FIN;
            s1_tiny  <= 1'b0;
            s1_rnd   <= RND_RNE;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_grs   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_cls  <= cls_d;
                s1_tiny <= tiny_d;
                s1_rnd  <= rnd_mode;
                s1_exp  <= exp_d;
                s1_frac <= frac_d;
                s1_grs  <= grs_d;
            end
        end
    end

    // ---------------- S2: round and pack ----------------
    logic                     near_up;
    logic                     rnd_up;
    logic                     inexact;
    logic                     ovf_rnd;
    logic [EXP_W+MAN_W-1:0]   mag;
    logic [EXP_W+MAN_W:0]     ovf_res;
    logic [EXP_W+MAN_W:0]     res_d;
    logic [3:0]               flags_d;

    always_comb begin
        inexact = |s1_grs;
        near_up = s1_grs[2] && (s1_grs[1] || s1_grs[0] || s1_frac[0]);
        rnd_up  = (s1_rnd == RND_RNE) && near_up;
        // Exponent and fraction are added as one word so a fraction carry-out
        // bumps the exponent, including denormal -> minimum normal.
        mag     = {s1_exp, s1_frac} + (EXP_W+MAN_W)'(rnd_up);
        // Overflow after rounding is judged on the nearest-rounded value, so
        // RTZ reports OF when the nearest result would have been infinite.
        ovf_rnd = (s1_exp == EXP_MAXF) && (&s1_frac) && near_up;
        ovf_res = (s1_rnd == RND_RNE) ? {s1_sign, EXP_ONES, {MAN_W{1'b0}}}
                                      : {s1_sign, EXP_MAXF, {MAN_W{1'b1}}};
        res_d   = '0;
        flags_d = '0;
        case (s1_cls)
            CLS_NAN: begin
                res_d            = NAN_BITS;
                flags_d[FLAG_NV] = 1'b1;
            end
            CLS_INF:  res_d = {s1_sign, EXP_ONES, {MAN_W{1'b0}}};
            CLS_ZERO: res_d = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
            CLS_OVF: begin
                res_d            = ovf_res;
                flags_d[FLAG_OF] = 1'b1;
                flags_d[FLAG_NX] = 1'b1;
            end
            default: begin
                if (ovf_rnd) begin
                    res_d            = ovf_res;
                    flags_d[FLAG_OF] = 1'b1;
                    flags_d[FLAG_NX] = 1'b1;
                end else begin
                    res_d            = {s1_sign, mag};
                    flags_d[FLAG_NX] = inexact;
                    flags_d[FLAG_UF] = s1_tiny && inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_d;
                out_flags  <= flags_d;
            end
        end
    end

    // A clear wipes the old contents; the beat accepted in the same cycle survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_flags <= '0;
        end else begin
            status_flags <= (flag_clr ? 4'b0 : status_flags)
                          | ((out_valid && out_ready) ? out_flags : 4'b0);
        end
    end

endmodule

// File: tb/tb_fpu_result_pack.sv
// Scoreboard bench for fpu_result_pack (EXP_W=8, MAN_W=23) with directed vectors.
// Latency: checks 2-cycle accept-to-output on an idle pipe.
// Backpressure: exercises out_ready stalls, flag clear/accept overlap and reset while stalled.
module tb_fpu_result_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [22:0] in_man;
    logic [2:0]  in_grs;
    logic        in_invalid;
    logic        in_inf;
    logic        in_zero;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        flag_clr;
    logic [3:0]  status_flags;

    always #5 clk = ~clk;

    fpu_result_pack #(.EXP_W(8), .MAN_W(23)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_man       (in_man),
        .in_grs       (in_grs),
        .in_invalid   (in_invalid),
        .in_inf       (in_inf),
        .in_zero      (in_zero),
        .rnd_mode     (rnd_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .flag_clr     (flag_clr),
        .status_flags (status_flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc_cyc;
        bit          chk_lat;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   accepted = 0;
    int   emitted  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drives one beat, pushes its expected response when the handshake is seen.
    task automatic send(input string name, input bit sgn, input int e, input logic [22:0] m,
                        input logic [2:0] grs, input bit inv, input bit inf, input bit zero,
                        input bit rnd, input logic [31:0] er, input logic [3:0] ef,
                        input bit lat = 1'b0);
        exp_t x;
        bit   done;
        done       = 1'b0;
        in_sign    = sgn;
        in_exp     = 10'(e);
        in_man     = m;
        in_grs     = grs;
        in_invalid = inv;
        in_inf     = inf;
        in_zero    = zero;
        rnd_mode   = rnd;
        in_valid   = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                x.res     = er;
                x.flg     = ef;
                x.acc_cyc = cyc;
                x.chk_lat = lat;
                x.name    = name;
                sbq.push_back(x);
                accepted++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept: in_ready stayed low for 200 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (sbq.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drain: %0d beats still outstanding", name, sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares on every output handshake.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: actual %0h required none", out_result);
                end else begin
                    x = sbq.pop_front();
                    emitted++;
                    check({x.name, " result"}, out_result, x.res);
                    check({x.name, " flags"}, 32'(out_flags), 32'(x.flg));
                    if (x.chk_lat) check({x.name, " latency"}, cyc - x.acc_cyc, 32'd2);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base_acc;
        int base_emit;
        bit seen;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp     = '0;
        in_man     = '0;
        in_grs     = '0;
        in_invalid = 1'b0;
        in_inf     = 1'b0;
        in_zero    = 1'b0;
        rnd_mode   = 1'b0;
        out_ready  = 1'b1;
        flag_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_flags", 32'(out_flags), 32'd0);
        check("reset status_flags", 32'(status_flags), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        //   name               sgn exp   man           grs   inv inf zro rnd  result         flags
        send("normal_one",      0, 127,  23'h000000,  3'b000, 0, 0, 0, 0, 32'h3F800000, 4'h0, 1'b1);
        drain("normal_one");
        send("rne_tie_odd",     0, 127,  23'h000001,  3'b100, 0, 0, 0, 0, 32'h3F800002, 4'h1);
        send("rtz_tie_odd",     0, 127,  23'h000001,  3'b100, 0, 0, 0, 1, 32'h3F800001, 4'h1);
        send("rne_tie_even",    0, 127,  23'h000002,  3'b100, 0, 0, 0, 0, 32'h3F800002, 4'h1);
        send("rne_carry_exp",   0, 127,  23'h7FFFFF,  3'b100, 0, 0, 0, 0, 32'h40000000, 4'h1);
        send("ovf_rnd_rne",     0, 254,  23'h7FFFFF,  3'b110, 0, 0, 0, 0, 32'h7F800000, 4'h5);
        send("ovf_rnd_rtz",     0, 254,  23'h7FFFFF,  3'b110, 0, 0, 0, 1, 32'h7F7FFFFF, 4'h5);
        send("ovf_pre_rne",     0, 300,  23'h000000,  3'b000, 0, 0, 0, 0, 32'h7F800000, 4'h5);
        send("ovf_pre_rtz_neg", 1, 300,  23'h000000,  3'b000, 0, 0, 0, 1, 32'hFF7FFFFF, 4'h5);
        send("denorm_sticky",   0, -1,   23'h000000,  3'b001, 0, 0, 0, 0, 32'h00200000, 4'h3);
        send("denorm_exact",    0, -1,   23'h000000,  3'b000, 0, 0, 0, 0, 32'h00200000, 4'h0);
        send("denorm_to_norm",  0, 0,    23'h7FFFFF,  3'b100, 0, 0, 0, 0, 32'h00800000, 4'h3);
        send("tiny_saturate",   1, -100, 23'h000000,  3'b000, 0, 0, 0, 0, 32'h80000000, 4'h3);
        send("invalid",         1, 127,  23'h123456,  3'b111, 1, 0, 0, 0, 32'h7FC00000, 4'h8);
        send("invalid_over_inf",0, 127,  23'h000000,  3'b000, 1, 1, 0, 0, 32'h7FC00000, 4'h8);
        send("inf_neg",         1, 127,  23'h000000,  3'b101, 0, 1, 0, 0, 32'hFF800000, 4'h0);
        send("inf_over_zero",   0, 127,  23'h000000,  3'b000, 0, 1, 1, 0, 32'h7F800000, 4'h0);
        send("zero_neg",        1, 127,  23'h000000,  3'b111, 0, 0, 1, 0, 32'h80000000, 4'h0);
        send("zero_over_ovf",   0, 300,  23'h000000,  3'b000, 0, 0, 1, 0, 32'h00000000, 4'h0);
        drain("directed");
        check("status_accum", 32'(status_flags), 32'hF);

        flag_clr = 1'b1;
        @(posedge clk);
        #1 flag_clr = 1'b0;
        @(negedge clk);
        check("status_clear", 32'(status_flags), 32'h0);
        @(posedge clk);
        #1;

        // Clear coinciding with an accepted beat keeps that beat's flags.
        send("ovf_for_status",  0, 300,  23'h000000,  3'b000, 0, 0, 0, 0, 32'h7F800000, 4'h5);
        drain("ovf_for_status");
        check("status_ovf", 32'(status_flags), 32'h5);
        out_ready = 1'b0;
        send("clr_vs_accept",   0, 127,  23'h000001,  3'b100, 0, 0, 0, 0, 32'h3F800002, 4'h1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("clr_vs_accept out_valid", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        flag_clr  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 flag_clr = 1'b0;
        @(negedge clk);
        check("status_clr_accept", 32'(status_flags), 32'h1);
        drain("clr_vs_accept");

        // Backpressure: four back-to-back beats with the sink stalled.
        base_acc  = accepted;
        base_emit = emitted;
        out_ready = 1'b0;
        fork
            begin
                send("bp0", 0, 127, 23'h000000, 3'b000, 0, 0, 0, 0, 32'h3F800000, 4'h0);
                send("bp1", 0, 128, 23'h000000, 3'b000, 0, 0, 0, 0, 32'h40000000, 4'h0);
                send("bp2", 0, 129, 23'h000000, 3'b000, 0, 0, 0, 0, 32'h40800000, 4'h0);
                send("bp3", 0, 130, 23'h000000, 3'b000, 0, 0, 0, 0, 32'h41000000, 4'h0);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp accepted_while_stalled", accepted - base_acc, 32'd2);
                check("bp in_ready_stalled", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp");
        check("bp emitted", emitted - base_emit, 32'd4);

        // Reset while both stages hold a stalled beat.
        out_ready = 1'b0;
        send("rst_a", 0, 127, 23'h000000, 3'b000, 0, 0, 0, 0, 32'h3F800000, 4'h0);
        send("rst_b", 0, 128, 23'h000000, 3'b000, 0, 0, 0, 0, 32'h40000000, 4'h0);
        @(negedge clk);
        check("pre_rst out_valid", 32'(out_valid), 32'd1);
        check("pre_rst status", 32'(status_flags), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst status_flags", 32'(status_flags), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send("post_rst_beat", 0, 127, 23'h000000, 3'b000, 0, 0, 0, 0, 32'h3F800000, 4'h0, 1'b1);
        drain("post_rst_beat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_result_pack.md
FPU_RESULT_PACK -- requirements
Module: fpu_result_pack

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width (hidden bit excluded).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream beat valid.
REQ-006 in_ready  out  1  block accepts the beat when in_valid && in_ready.
REQ-007 in_sign  in  1  result sign.
REQ-008 in_exp  in  EXP_W+2  signed biased exponent; values <= 0 mean tiny, >= 2^EXP_W-1 mean overflow.
REQ-009 in_man  in  MAN_W  normalized fraction with an implied hidden 1.
REQ-010 in_grs  in  3  guard, round, sticky bits.
REQ-011 in_invalid / in_inf / in_zero  in  1 each  upstream classification.
REQ-012 rnd_mode  in  1  0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled with the beat.
REQ-013 out_valid  out  1 and out_ready  in  1  downstream handshake.
REQ-014 out_result  out  1+EXP_W+MAN_W  packed {sign, exp, frac}.
REQ-015 out_flags  out  4  per-beat {NV, OF, UF, NX}.
REQ-016 flag_clr  in  1 and status_flags  out  4  sticky accumulated flags and their clear.

Function
REQ-017 Two-stage pipeline: S1 = classify and denormalize; S2 = round and pack; latency exactly 2 cycles when there is no stall.
REQ-018 A stage loads when it is empty or its contents advance in the same cycle; in_ready = !S1_valid || S1 advancing. Full throughput is one beat per cycle.
REQ-019 While out_valid && !out_ready, out_result and out_flags hold stable; no beat is lost, duplicated or reordered.
REQ-020 Priority: invalid > inf > zero > overflow > tiny > normal.
REQ-021 invalid: canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0), flags NV.
REQ-022 inf: {in_sign, all-ones exponent, 0}, no flags.
REQ-023 zero: {in_sign, 0, 0}, no flags.
REQ-024 Tiny (in_exp <= 0): shift {1, in_man, grs} right by 1 - in_exp, saturated at MAN_W+3; every shifted-out bit is ORed into sticky; exponent is forced to 0.
REQ-025 Rounding: RNE increments when G && (R || S || lsb); RTZ truncates. NX = G || R || S after alignment.
REQ-026 A rounding carry-out increments the exponent. A denormal that rounds up to the minimum normal gets exponent 1.
REQ-027 Overflow (exponent >= 2^EXP_W-1 before or after rounding): RNE gives ±inf, RTZ gives ±max finite; flags OF|NX.
REQ-028 UF is raised only when the value is tiny before rounding and NX is set.
REQ-029 On each accepted output beat, status_flags |= out_flags. flag_clr clears the previous contents; if clear and accept coincide, the accepted beat's flags are kept.

Reset
REQ-030 On rst: both stage-valid bits = 0, out_valid = 0, out_result = 0, out_flags = 0, status_flags = 0, in_ready = 1 from the first cycle after deassertion.
REQ-031 Beats in flight when rst asserts are discarded and never emitted.

Structure
REQ-032 Shared package fpu_pkg holds the flag bit indices (NV=3, OF=2, UF=1, NX=0), the rnd_mode encodings, and a canonical-NaN constant function of EXP_W/MAN_W.
REQ-033 S1 right shift with sticky collection lives in sub-module fpu_denorm_shifter, parametrised by MAN_W.

Verification (EXP_W=8, MAN_W=23)
REQ-034 Normal: exp=127, man=0, grs=000 -> 0x3F800000, flags 0, out_valid 2 cycles after accept.
REQ-035 RNE tie: exp=127, man=0x000001, grs=100 -> 0x3F800002, NX; same beat with RTZ -> 0x3F800001, NX.
REQ-036 Overflow: exp=254, man=0x7FFFFF, grs=110 -> RNE 0x7F800000, RTZ 0x7F7FFFFF; both OF|NX.
REQ-037 Denormal: exp=-1, man=0, grs=001, RNE -> 0x00200000, UF|NX; with grs=000 -> 0x00200000, flags 0.
REQ-038 Backpressure: 4 back-to-back beats with out_ready low for 5 cycles -> in_ready low after 2 beats accepted, all 4 outputs emitted in order, no duplicates.
REQ-039 rst pulsed while stalled with both stages full -> out_valid=0 and status_flags=0 the next cycle; no stale beat after release.
